mips_lsu: RTL and testbench

Parametrised load/store unit for the multi-cycle MIPS core. It takes one memory instruction at a time from the core's EX stage over a valid/ready request channel and drives the core's memory request and read-response channels. It performs MIPS byte-lane formatting for every load/store flavour and returns the write-back value over a valid/ready response channel. Load and store cycle counters are built in and feed the core's performance-counter outputs.

---
 rtl/mips_lsu_if.sv | 57 +++++
 rtl/mips_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lsu_if
//  Description : Bundles the request/response and memory channels of the
//                MIPS load/store unit. "slave" is the LSU view; "master" is
//                the view of the core plus memory system driving it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_lsu_if #(
    parameter int ADDR_W = 32
) ();
    // core request channel
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // core response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    // memory request channel
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_req_ready;
    // memory read-response channel
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        input  resp_ready,
        input  mem_req_ready,
        input  rd_data, rd_valid,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        output mem_addr, mem_read, mem_write, mem_wdata, mem_wstrb,
        output rd_ready
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        output resp_ready,
        output mem_req_ready,
        output rd_data, rd_valid,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        input  mem_addr, mem_read, mem_write, mem_wdata, mem_wstrb,
        input  rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lsu
//  Description : Load/store unit for the multi-cycle MIPS core. Accepts one
//                memory instruction at a time, performs MIPS byte-lane
//                formatting for every load/store flavour, and counts the
//                cycles spent in load and store traffic.
//                Optional feature macro: LSU_ALIGN_CHECK_EN (reject
//                misaligned lh/lhu/sh/lw/sw instead of ignoring low bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_lsu #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mips_lsu_if.slave        bus,
    output logic [CNT_W-1:0] ld_cycles,
    output logic [CNT_W-1:0] st_cycles
);

    // state encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LD_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_RD = 3'd2;
    localparam logic [2:0] c_ST_ST_REQ  = 3'd3;
    localparam logic [2:0] c_ST_RESP    = 3'd4;

    // opcodes IR[31:26]
    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LH  = 6'b100001;
    localparam logic [5:0] c_OP_LWL = 6'b100010;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_LBU = 6'b100100;
    localparam logic [5:0] c_OP_LHU = 6'b100101;
    localparam logic [5:0] c_OP_LWR = 6'b100110;
    localparam logic [5:0] c_OP_SB  = 6'b101000;
    localparam logic [5:0] c_OP_SH  = 6'b101001;
    localparam logic [5:0] c_OP_SWL = 6'b101010;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_SWR = 6'b101110;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [5:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_resp_data;
    logic              r_resp_err;
    logic [CNT_W-1:0]  r_ld_cycles;
    logic [CNT_W-1:0]  r_st_cycles;

    logic              w_req_load;
    logic              w_req_store;
    logic              w_misalign;
    logic              w_accept;
    logic [1:0]        w_lane;
    logic [4:0]        w_sh_lo;
    logic [4:0]        w_sh_hi;
    logic [31:0]       w_rd_shifted;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_st_data;
    logic [3:0]        w_st_strb;

    // classify the incoming opcode as load, store or unsupported
    always_comb begin
        w_req_load  = 1'b0;
        w_req_store = 1'b0;
        case (bus.req_op)
            c_OP_LB, c_OP_LH, c_OP_LWL, c_OP_LW,
            c_OP_LBU, c_OP_LHU, c_OP_LWR:        w_req_load  = 1'b1;
            c_OP_SB, c_OP_SH, c_OP_SWL, c_OP_SW,
            c_OP_SWR:                            w_req_store = 1'b1;
            default: ;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    // halfword/word accesses must be naturally aligned; lwl/lwr/swl/swr and
    // byte accesses can never be misaligned
    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_op)
            c_OP_LH, c_OP_LHU, c_OP_SH: w_misalign = bus.req_addr[0];
            c_OP_LW, c_OP_SW:           w_misalign = |bus.req_addr[1:0];
            default: ;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == c_ST_IDLE) && bus.req_valid;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_load && !w_misalign)       w_state_nxt = c_ST_LD_REQ;
                    else if (w_req_store && !w_misalign) w_state_nxt = c_ST_ST_REQ;
                    else                                 w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_LD_REQ:  if (bus.mem_req_ready) w_state_nxt = c_ST_WAIT_RD;
            c_ST_WAIT_RD: if (bus.rd_valid)      w_state_nxt = c_ST_RESP;
            c_ST_ST_REQ:  if (bus.mem_req_ready) w_state_nxt = c_ST_RESP;
            c_ST_RESP:    if (bus.resp_ready)    w_state_nxt = c_ST_IDLE;
            default:                             w_state_nxt = c_ST_IDLE;
        endcase
    end

    // effective byte lane: low bits below the access size are ignored
    always_comb begin
        w_lane = r_addr[1:0];
        case (r_op)
            c_OP_LH, c_OP_LHU, c_OP_SH: w_lane = {r_addr[1], 1'b0};
            c_OP_LW, c_OP_SW:           w_lane = 2'b00;
            default: ;
        endcase
    end

    // 8*a and 8*(3-a); 3-a on two bits is simply ~a
    assign w_sh_lo      = {w_lane, 3'b000};
    assign w_sh_hi      = {~w_lane, 3'b000};
    assign w_rd_shifted = bus.rd_data >> w_sh_lo;

    // load result formatting, including the lwl/lwr merge with rt
    always_comb begin
        w_ld_data = bus.rd_data;
        case (r_op)
            c_OP_LB:  w_ld_data = {{24{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            c_OP_LBU: w_ld_data = {24'h0, w_rd_shifted[7:0]};
            c_OP_LH:  w_ld_data = {{16{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            c_OP_LHU: w_ld_data = {16'h0, w_rd_shifted[15:0]};
            c_OP_LWL: w_ld_data = (bus.rd_data << w_sh_hi)
                                | (r_wdata & ~(32'hFFFF_FFFF << w_sh_hi));
            c_OP_LWR: w_ld_data = w_rd_shifted
                                | (r_wdata & ~(32'hFFFF_FFFF >> w_sh_lo));
            default: ;
        endcase
    end

    // store lane shifting and strobes; held at zero outside the write request
    always_comb begin
        w_st_data = 32'h0;
        w_st_strb = 4'h0;
        if (r_state == c_ST_ST_REQ) begin
            case (r_op)
                c_OP_SB: begin
                    w_st_data = r_wdata << w_sh_lo;
                    w_st_strb = 4'b0001 << w_lane;
                end
                c_OP_SH: begin
                    w_st_data = r_wdata << w_sh_lo;
                    w_st_strb = 4'b0011 << w_lane;
                end
                c_OP_SW: begin
                    w_st_data = r_wdata;
                    w_st_strb = 4'b1111;
                end
                c_OP_SWL: begin
                    w_st_data = r_wdata >> w_sh_hi;
                    w_st_strb = ~(4'b1110 << w_lane);
                end
                c_OP_SWR: begin
                    w_st_data = r_wdata << w_sh_lo;
                    w_st_strb = 4'b1111 << w_lane;
                end
                default: ;
            endcase
        end
    end

    // request latch, response capture and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 6'h0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
            r_ld_cycles <= '0;
            r_st_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= bus.req_op;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_resp_data <= 32'h0;
                r_resp_err  <= !((w_req_load || w_req_store) && !w_misalign);
            end
            if ((r_state == c_ST_WAIT_RD) && bus.rd_valid) begin
                r_resp_data <= w_ld_data;
            end
            if ((r_state == c_ST_LD_REQ) || (r_state == c_ST_WAIT_RD)) begin
                r_ld_cycles <= r_ld_cycles + 1'b1;
            end
            if (r_state == c_ST_ST_REQ) begin
                r_st_cycles <= r_st_cycles + 1'b1;
            end
        end
    end

    // outputs are state decodes or registered values only
    assign bus.req_ready  = (r_state == c_ST_IDLE);
    assign bus.resp_valid = (r_state == c_ST_RESP);
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.mem_read   = (r_state == c_ST_LD_REQ);
    assign bus.mem_write  = (r_state == c_ST_ST_REQ);
    assign bus.mem_wdata  = w_st_data;
    assign bus.mem_wstrb  = w_st_strb;
    // drain any stale read response while in reset
    assign bus.rd_ready   = (r_state == c_ST_WAIT_RD) || rst;
    assign ld_cycles      = r_ld_cycles;
    assign st_cycles      = r_st_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_lsu
//  Description : Scoreboard bench for mips_lsu. The driver pushes expected
//                responses and memory requests; independent monitors pop
//                and compare them when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_lsu;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LWL = 6'b100010;
    localparam logic [5:0] LW  = 6'b100011, LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] LWR = 6'b100110, SB  = 6'b101000, SH  = 6'b101001;
    localparam logic [5:0] SWL = 6'b101010, SW  = 6'b101011, SWR = 6'b101110;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] ld_cycles;
    logic [CNT_W-1:0] st_cycles;

    mips_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    mips_lsu #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ld_cycles (ld_cycles),
        .st_cycles (st_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          mwait;
    } mem_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          mwait;
        int          stall;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        int          dld;
        int          dst;
    } vec_t;

    resp_t exp_q[$];
    mem_t  mem_q[$];
    vec_t  vq[$];

    int checks       = 0;
    int errors       = 0;
    int resp_seen    = 0;
    int stall_cycles = 0;
    bit block_rd     = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [5:0] op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int mwait, int stall,
                                logic [31:0] exp_data, logic exp_err, logic [31:0] maddr,
                                logic [3:0] strb, logic [31:0] mwdata, int dld, int dst);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.mwait = mwait; v.stall = stall; v.exp_data = exp_data; v.exp_err = exp_err;
        v.maddr = maddr; v.strb = strb; v.mwdata = mwdata; v.dld = dld; v.dst = dst;
        return v;
    endfunction

    // response monitor: pops the scoreboard on every resp handshake
    initial begin
        resp_t r;
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.resp_ready = 1'b0;
            end else if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
                    bus.resp_ready = 1'b1;
                end else if (stall_cycles > 0) begin
                    bus.resp_ready = 1'b0;
                    stall_cycles--;
                    chk("resp_data_stable", bus.resp_data, exp_q[0].data);
                    chk("resp_err_stable", {31'h0, bus.resp_err}, {31'h0, exp_q[0].err});
                end else begin
                    bus.resp_ready = 1'b1;
                    r = exp_q.pop_front();
                    chk("resp_data", bus.resp_data, r.data);
                    chk("resp_err", {31'h0, bus.resp_err}, {31'h0, r.err});
                    resp_seen++;
                end
            end else begin
                bus.resp_ready = 1'b0;
            end
        end
    end

    // memory model/monitor: checks each request and serves it after mwait cycles
    initial begin
        mem_t cur;
        bit   in_req;
        bit   rd_pend;
        int   hold;
        in_req = 1'b0; rd_pend = 1'b0; hold = 0;
        cur = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        bus.mem_req_ready = 1'b0;
        bus.rd_valid      = 1'b0;
        bus.rd_data       = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.rd_valid      = 1'b0;
            bus.rd_data       = 32'h5A5A_5A5A;
            if (rst) begin
                in_req  = 1'b0;
                rd_pend = 1'b0;
            end else if (rd_pend) begin
                if (bus.rd_ready && !block_rd) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = cur.rdata;
                    rd_pend      = 1'b0;
                end
            end else if (bus.mem_read || bus.mem_write) begin
                if (!in_req) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
                        bus.mem_req_ready = 1'b1;
                        rd_pend   = bus.mem_read;
                        cur.rdata = 32'h0;
                    end else begin
                        cur    = mem_q.pop_front();
                        in_req = 1'b1;
                        hold   = 0;
                    end
                end
                if (in_req) begin
                    chk("mem_write", {31'h0, bus.mem_write}, {31'h0, cur.wr});
                    chk("mem_read", {31'h0, bus.mem_read}, {31'h0, !cur.wr});
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    if (cur.wr) begin
                        chk("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, cur.strb});
                        chk("mem_wdata", bus.mem_wdata, cur.wdata);
                    end
                    hold++;
                    if (hold > cur.mwait) begin
                        bus.mem_req_ready = 1'b1;
                        in_req  = 1'b0;
                        rd_pend = !cur.wr;
                    end
                end
            end
        end
    end

    task automatic drive_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_timeout", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 6'h3F;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [CNT_W-1:0] ld0, st0;
        int target;
        int n;
        exp_q.push_back('{v.exp_data, v.exp_err});
        if (!v.exp_err)
            mem_q.push_back('{v.op[3], v.maddr, v.strb, v.mwdata, v.rdata, v.mwait});
        stall_cycles = v.stall;
        target = resp_seen + 1;
        while (!bus.req_ready) @(negedge clk);
        ld0 = ld_cycles;
        st0 = st_cycles;
        drive_req(v.op, v.addr, v.wdata);
        n = 0;
        while (resp_seen < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("vec%0d_resp_count", id), resp_seen, target);
        @(negedge clk);
        chk($sformatf("vec%0d_ld_cycles", id), ld_cycles - ld0, v.dld);
        chk($sformatf("vec%0d_st_cycles", id), st_cycles - st0, v.dst);
        if (resp_seen < target) begin
            // resynchronise after a hung access
            exp_q.delete();
            mem_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            resp_seen = target;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 6'h0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_ready", {31'h0, bus.rd_ready}, 32'h1);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        chk("rst_mem_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        chk("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        chk("rst_ld_cycles", ld_cycles, 32'h0);
        chk("rst_st_cycles", st_cycles, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rd_ready", {31'h0, bus.rd_ready}, 32'h0);

        //            op   addr          wdata         rdata        mw st  exp_data      err  maddr        strb     mwdata        dld dst
        vq.push_back(mk(LB,  32'h1003, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFF_FF80, 0, 32'h1000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LBU, 32'h1003, 32'h0,        32'h80FF_0000, 0, 0, 32'h0000_0080, 0, 32'h1000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LH,  32'h1002, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFF_80FF, 0, 32'h1000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LHU, 32'h1000, 32'h0,        32'h1234_8001, 0, 0, 32'h0000_8001, 0, 32'h1000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LW,  32'h1004, 32'h0,        32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 0, 32'h1004, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LWL, 32'h2001, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h3344_CCDD, 0, 32'h2000, 4'b0000, 32'h0,       2, 0));
        vq.push_back(mk(LWR, 32'h2001, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'hAA11_2233, 0, 32'h2000, 4'b0000, 32'h0,       2, 0));
        vq.push_back(mk(LWL, 32'h2000, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h44BB_CCDD, 0, 32'h2000, 4'b0000, 32'h0,       2, 0));
        vq.push_back(mk(LWR, 32'h2003, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'hAABB_CC11, 0, 32'h2000, 4'b0000, 32'h0,       2, 0));
        vq.push_back(mk(SWL, 32'h3002, 32'hAABB_CCDD, 32'h0,         0, 0, 32'h0,         0, 32'h3000, 4'b0111, 32'h00AA_BBCC, 0, 1));
        vq.push_back(mk(SH,  32'h4002, 32'h1122_5566, 32'h0,         3, 0, 32'h0,         0, 32'h4000, 4'b1100, 32'h5566_0000, 0, 4));
        vq.push_back(mk(SB,  32'h4001, 32'h0000_00A5, 32'h0,         0, 0, 32'h0,         0, 32'h4000, 4'b0010, 32'h0000_A500, 0, 1));
        vq.push_back(mk(SW,  32'h4008, 32'hCAFE_F00D, 32'h0,         0, 1, 32'h0,         0, 32'h4008, 4'b1111, 32'hCAFE_F00D, 0, 1));
        vq.push_back(mk(SWR, 32'h4001, 32'hAABB_CCDD, 32'h0,         0, 0, 32'h0,         0, 32'h4000, 4'b1110, 32'hBBCC_DD00, 0, 1));
        vq.push_back(mk(SWL, 32'h4000, 32'hAABB_CCDD, 32'h0,         0, 0, 32'h0,         0, 32'h4000, 4'b0001, 32'h0000_00AA, 0, 1));
        vq.push_back(mk(6'b000000, 32'h0100, 32'h1234_5678, 32'h0,   0, 0, 32'h0,         1, 32'h0,    4'b0000, 32'h0,        0, 0));
        vq.push_back(mk(6'b101100, 32'h0104, 32'h1234_5678, 32'h0,   0, 0, 32'h0,         1, 32'h0,    4'b0000, 32'h0,        0, 0));
        vq.push_back(mk(LBU, 32'h6002, 32'h0,        32'h00AB_0000, 2, 0, 32'h0000_00AB, 0, 32'h6000, 4'b0000, 32'h0,        4, 0));
`ifdef LSU_ALIGN_CHECK_EN
        vq.push_back(mk(LW,  32'h5002, 32'h0,        32'h0102_0304, 0, 0, 32'h0,         1, 32'h0,    4'b0000, 32'h0,        0, 0));
        vq.push_back(mk(LH,  32'h5001, 32'h0,        32'h80FF_7F01, 0, 0, 32'h0,         1, 32'h0,    4'b0000, 32'h0,        0, 0));
        vq.push_back(mk(SH,  32'h4003, 32'h0000_BEEF, 32'h0,        0, 0, 32'h0,         1, 32'h0,    4'b0000, 32'h0,        0, 0));
`else
        vq.push_back(mk(LW,  32'h5002, 32'h0,        32'h0102_0304, 0, 0, 32'h0102_0304, 0, 32'h5000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(LH,  32'h5001, 32'h0,        32'h80FF_7F01, 0, 0, 32'h0000_7F01, 0, 32'h5000, 4'b0000, 32'h0,        2, 0));
        vq.push_back(mk(SH,  32'h4003, 32'h0000_BEEF, 32'h0,        0, 0, 32'h0,         0, 32'h4000, 4'b1100, 32'hBEEF_0000, 0, 1));
`endif

        foreach (vq[i]) run_vec(vq[i], i);

        // reset while waiting for read data abandons the access
        begin
            int n = 0;
            block_rd = 1'b1;
            mem_q.push_back('{1'b0, 32'h5000, 4'b0000, 32'h0, 32'h7777_7777, 0});
            drive_req(LW, 32'h5000, 32'h0);
            while (!bus.rd_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reached_wait_rd", {31'h0, bus.rd_ready}, 32'h1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            block_rd = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk($sformatf("post_rst_resp_valid%0d", k), {31'h0, bus.resp_valid}, 32'h0);
            end
            chk("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
            chk("post_rst_ld_cycles", ld_cycles, 32'h0);
        end

        // normal operation resumes after the abandoned access
        run_vec(mk(LB, 32'h7001, 32'h0, 32'h0000_7F00, 0, 0, 32'h0000_007F, 0, 32'h7000, 4'b0000, 32'h0, 2, 0), 99);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
